// File: rtl/pcbfpga_cfg_pkg.sv
// Shared types and constants for the serially configured LUT+FF cell.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcbfpga_cfg_pkg;

    // Configuration loader states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } cfg_state_t;

    // Per-channel flag bits, offsets relative to the top of the 2**K INIT field
    localparam int OFS_NO_ENABLE        = 0;
    localparam int OFS_HAS_RESET        = 1;
    localparam int OFS_ACTIVE_LOW_RESET = 2;
    localparam int OFS_REGISTERED       = 3;
    localparam int CHAN_FLAGS           = 4;

    // Total configuration bits for N channels of K-input LUTs
    function automatic int cfg_width(input int k, input int n);
        return n * ((2 ** k) + CHAN_FLAGS);
    endfunction

endpackage

// File: rtl/pcbfpga_cfg_chan.sv
// One K-input LUT followed by an optional enable/reset flop, selected by its config word.
// Latency: 0 cycles when combinational, 1 cycle when REGISTERED.
// Backpressure: none; output is a free-running fabric signal.
module pcbfpga_cfg_chan
    import pcbfpga_cfg_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [(2**K)+CHAN_FLAGS-1:0] i_cfg,
    input  logic                        i_configured,
    input  logic                        i_commit,
    input  logic [K-1:0]                i_sel,
    input  logic                        i_en,
    input  logic                        i_frst,
    output logic                        o_f
);

    localparam int LUT_N = 2 ** K;

    logic [LUT_N-1:0] w_init;
    logic             w_lut;
    logic             w_no_en;
    logic             w_has_rst;
    logic             w_rst_low;
    logic             w_registered;
    logic             w_q_upd;
    logic             w_q_clr;
    logic             r_q;

    assign w_init       = i_cfg[LUT_N-1:0];
    assign w_lut        = w_init[i_sel];
    assign w_no_en      = i_cfg[LUT_N + OFS_NO_ENABLE];
    assign w_has_rst    = i_cfg[LUT_N + OFS_HAS_RESET];
    assign w_rst_low    = i_cfg[LUT_N + OFS_ACTIVE_LOW_RESET];
    assign w_registered = i_cfg[LUT_N + OFS_REGISTERED];

    // Fabric reset only acts on an enabled edge, so it behaves as a synchronous clear
    assign w_q_upd = i_configured & (i_en | w_no_en);
    assign w_q_clr = w_has_rst & (i_frst ^ w_rst_low);

    // Channel flop: cleared on commit so a new configuration starts from a known state
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= 1'b0;
        end else if (i_commit) begin
            r_q <= 1'b0;
        end else if (w_q_upd) begin
            r_q <= w_q_clr ? 1'b0 : w_lut;
        end
    end

    assign o_f = i_configured & (w_registered ? r_q : w_lut);

endmodule

// File: rtl/pcbfpga_cfg_cell.sv
// N LUT+FF channels loaded through a serial shadow register, committed atomically.
// Latency: CFG_DONE rises CFG_W+2 cycles after CFG_START with CFG_EN held high.
// Backpressure: CFG_EN low stalls the load; old configuration keeps running until commit.
module pcbfpga_cfg_cell
    import pcbfpga_cfg_pkg::*;
#(
    parameter int K = 4,
    parameter int N = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CFG_START,
    input  logic           CFG_EN,
    input  logic           CFG_DI,
    output logic           CFG_DO,
    output logic           CFG_DONE,
    input  logic [N*K-1:0] I,
    input  logic [N-1:0]   EN,
    input  logic [N-1:0]   FRST,
    output logic [N-1:0]   F
);

    localparam int CFG_W = cfg_width(K, N);
    localparam int CH_W  = (2 ** K) + CHAN_FLAGS;
    localparam int CNT_W = $clog2(CFG_W + 1);

    cfg_state_t       r_state;
    cfg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CFG_W-1:0] r_shadow;
    logic [CFG_W-1:0] r_active;
    logic             r_configured;
    logic             r_done;
    logic             w_clr_cnt;
    logic             w_shift;
    logic             w_commit;

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a restart inside SHIFT wins over a shift in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (CFG_START) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!CFG_START && CFG_EN && (w_cnt_inc == CNT_W'(CFG_W)))
                    w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Per-state control strobes
    always_comb begin
        w_clr_cnt = 1'b0;
        w_shift   = 1'b0;
        w_commit  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: w_clr_cnt = CFG_START;
            ST_SHIFT: begin
                w_clr_cnt = CFG_START;
                w_shift   = !CFG_START && CFG_EN;
            end
            ST_COMMIT: w_commit = 1'b1;
            default: ;
        endcase
    end

    // Shadow shift register and qualified-bit counter
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_shadow <= '0;
        end else if (w_clr_cnt) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt    <= w_cnt_inc;
            r_shadow <= {r_shadow[CFG_W-2:0], CFG_DI};
        end
    end

    // Atomic transfer of the completed load into the live configuration
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_active     <= '0;
            r_configured <= 1'b0;
        end else if (w_commit) begin
            r_active     <= r_shadow;
            r_configured <= 1'b1;
        end
    end

    // Done flag tracks the DONE state as a flop
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (w_state_nxt == ST_DONE);
        end
    end

    assign CFG_DONE = r_done;
    assign CFG_DO   = r_shadow[CFG_W-1];

    for (genvar c = 0; c < N; c++) begin : g_chan
        pcbfpga_cfg_chan #(.K(K)) u_chan (
            .i_clk        (CLK),
            .i_rst        (RST),
            .i_cfg        (r_active[c*CH_W +: CH_W]),
            .i_configured (r_configured),
            .i_commit     (w_commit),
            .i_sel        (I[c*K +: K]),
            .i_en         (EN[c]),
            .i_frst       (FRST[c]),
            .o_f          (F[c])
        );
    end

endmodule

// File: doc/pcbfpga_cfg_cell.md
PCBFPGA_CFG_CELL -- requirements
Module: pcbfpga_cfg_cell

Interface
REQ-001 Parameter K, default 4, LUT input count per channel.
REQ-002 Parameter N, default 2, number of LUT+FF channels.
REQ-003 Derived constant CFG_W = N*(2**K+4), total configuration bits.
REQ-004 CLK  input  1  single clock; all state updates on the rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 CFG_START  input  1  one-cycle pulse that begins a configuration load.
REQ-007 CFG_EN  input  1  qualifies CFG_DI; one shift per cycle high in SHIFT.
REQ-008 CFG_DI  input  1  serial configuration data, MSB of the stream first.
REQ-009 CFG_DO  output  1  scan-out, equal to shadow register bit CFG_W-1.
REQ-010 CFG_DONE  output  1  registered; high while state is DONE.
REQ-011 I  input  N*K  LUT inputs; channel c uses I[c*K +: K].
REQ-012 EN  input  N  per-channel FF enable.
REQ-013 FRST  input  N  per-channel fabric reset, polarity set by configuration.
REQ-014 F  output  N  per-channel output.

Function
REQ-015 Config FSM states: IDLE, SHIFT, COMMIT, DONE.
REQ-016 IDLE/DONE with CFG_START=1 -> SHIFT next cycle, bit counter cleared; CFG_EN ignored in that cycle.
REQ-017 SHIFT with CFG_EN=1 -> shadow <= {shadow[CFG_W-2:0], CFG_DI}, counter+1; CFG_EN=0 stalls shadow and counter.
REQ-018 SHIFT, shift that brings counter to CFG_W -> COMMIT next cycle; counter width $clog2(CFG_W+1).
REQ-019 SHIFT with CFG_START=1 -> counter cleared, no shift that cycle, remain in SHIFT.
REQ-020 COMMIT lasts exactly one cycle: active config <= shadow, configured flag <= 1, all channel FFs <= 0; then DONE.
REQ-021 CFG_EN and CFG_DI ignored outside SHIFT; CFG_START ignored in COMMIT.
REQ-022 Latency: CFG_START at cycle t with CFG_EN continuously high -> CFG_DONE first high in cycle t+CFG_W+2.
REQ-023 Per-channel field layout in shadow/active, channel 0 at LSB: [2**K-1:0] INIT, then NO_ENABLE, HAS_RESET, ACTIVE_LOW_RESET, REGISTERED.
REQ-024 lut_c = INIT_c[I_c]; REGISTERED=0 -> F[c] = lut_c combinationally; REGISTERED=1 -> F[c] = Q_c.
REQ-025 Q_c updates only when configured=1, state != COMMIT, and (EN[c] | NO_ENABLE_c): Q_c <= 0 if HAS_RESET_c & (FRST[c] ^ ACTIVE_LOW_RESET_c), else lut_c.
REQ-026 During SHIFT the previous active configuration keeps driving F and Q; only COMMIT changes behaviour.
REQ-027 configured=0 -> F = 0 on all channels regardless of I.

Reset
REQ-028 RST=1 -> immediately: state IDLE, counter 0, shadow 0, active config 0, configured 0, all Q 0, CFG_DONE 0, F 0, CFG_DO 0.
REQ-029 RST asserted mid-SHIFT or in COMMIT discards the partial load; configured stays 0 until a complete load commits.

Structure
REQ-030 Package pcbfpga_cfg_pkg holds the FSM state enum, field offset constants (NO_ENABLE, HAS_RESET, ACTIVE_LOW_RESET, REGISTERED relative to 2**K) and a cfg-width function of K and N.
REQ-031 Sub-module pcbfpga_cfg_chan implements one LUT+FF channel and is instantiated N times; FSM, counter and shadow/active registers live in the top.

Verification (K=4, N=2, CFG_W=40)
REQ-032 Reset: RST pulsed after 20 shifts -> CFG_DONE=0, F=2'b00, new CFG_START needs a full 40 further shifts.
REQ-033 Load ch0 INIT=16'h8000 combinational and ch1 INIT=16'h6996 REGISTERED, NO_ENABLE=1, CFG_START at t -> CFG_DONE=1 at t+42; I0=4'hF -> F[0]=1 same cycle; I1=4'h1 -> F[1]=1 after the next edge.
REQ-034 Enable: ch1 NO_ENABLE=0, EN[1]=0, I1 toggled -> F[1] holds; EN[1]=1 -> F[1] follows lut after one edge.
REQ-035 Fabric reset: HAS_RESET=1, ACTIVE_LOW_RESET=1, EN=1, FRST[1]=0 -> Q=0 next edge; FRST[1]=1 -> Q=lut.
REQ-036 Restart: CFG_START at shift 20 -> CFG_DONE only after 40 further CFG_EN cycles plus COMMIT; the old config drives F throughout.
REQ-037 Stalls and scan: random CFG_EN gaps -> commit after exactly 40 qualified shifts; CFG_DO reproduces the CFG_DI stream delayed by 40 qualified shifts.
